sdram_fifo_sched: RTL

- Single-clock burst scheduler between the write/read data FIFOs and the SDRAM command controller.
- Drains the write FIFO into SDRAM in fixed-length bursts and refills the read FIFO from SDRAM in the same bursts.
- Treats SDRAM as a circular region of whole bursts and tracks how many stored bursts remain unread.
- Arbitrates the one SDRAM port between write-drain and read-refill.

---
 rtl/sdram_fifo_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sdram_fifo_sched.sv
// Burst scheduler moving data between the write/read FIFOs and one SDRAM port.
// Define SDRAM_SCHED_RR_EN for round-robin arbitration; otherwise writes have priority.
module sdram_fifo_sched #(
  parameter int unsigned ADDR_WIDTH    = 24,
  parameter int unsigned USE_WIDTH     = 10,
  parameter int unsigned BURST_LEN     = 8,
  parameter int unsigned REGION_BURSTS = 1024,
  parameter int unsigned RFIFO_DEPTH   = 512
) (
  input  logic                               clk,
  input  logic                               clr,
  input  logic [USE_WIDTH-1:0]               wfifo_use_num,
  output logic                               wfifo_rd_req,
  input  logic [USE_WIDTH-1:0]               rfifo_use_num,
  output logic                               rfifo_wr_req,
  input  logic                               rd_en,
  output logic                               sd_req,
  output logic                               sd_we,
  output logic [ADDR_WIDTH-1:0]              sd_addr,
  input  logic                               sd_ack,
  input  logic                               sd_wr_beat,
  input  logic                               sd_rd_beat,
  output logic [$clog2(REGION_BURSTS):0]     stored_bursts,
  output logic                               busy
);

  localparam int unsigned BW = $clog2(BURST_LEN);
  localparam int unsigned PW = $clog2(REGION_BURSTS);
  localparam int unsigned SW = PW + 1;
  localparam logic [BW-1:0] LastBeat = BW'(BURST_LEN - 1);
  localparam int unsigned RdThresh = RFIFO_DEPTH - BURST_LEN;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrBurst,
    StRdReq,
    StRdBurst
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] stored_q, stored_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  logic wr_elig, rd_elig;
  logic grant_wr, grant_rd;

`ifdef SDRAM_SCHED_RR_EN
  // 1 = write was granted last, 0 = read (reset value).
  logic last_grant_q, last_grant_d;
`endif

  always_comb begin
    wr_elig = (32'(wfifo_use_num) >= BURST_LEN) && (32'(stored_q) < REGION_BURSTS);
    rd_elig = rd_en && (stored_q != '0) && (32'(rfifo_use_num) <= RdThresh);
`ifdef SDRAM_SCHED_RR_EN
    grant_wr = wr_elig && (!rd_elig || !last_grant_q);
`else
    grant_wr = wr_elig;
`endif
    grant_rd = rd_elig && !grant_wr;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    stored_d   = stored_q;
    beat_cnt_d = beat_cnt_q;
`ifdef SDRAM_SCHED_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_wr) begin
          state_d = StWrReq;
`ifdef SDRAM_SCHED_RR_EN
          last_grant_d = 1'b1;
`endif
        end else if (grant_rd) begin
          state_d = StRdReq;
`ifdef SDRAM_SCHED_RR_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      StWrReq: begin
        if (sd_ack) state_d = StWrBurst;
      end
      StWrBurst: begin
        if (sd_wr_beat) begin
          if (beat_cnt_q == LastBeat) begin
            state_d    = StIdle;
            beat_cnt_d = '0;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            stored_d   = stored_q + 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      StRdReq: begin
        if (sd_ack) state_d = StRdBurst;
      end
      StRdBurst: begin
        if (sd_rd_beat) begin
          if (beat_cnt_q == LastBeat) begin
            state_d    = StIdle;
            beat_cnt_d = '0;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            stored_d   = stored_q - 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      stored_q   <= '0;
      beat_cnt_q <= '0;
`ifdef SDRAM_SCHED_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      stored_q   <= stored_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef SDRAM_SCHED_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Outputs decode the async-reset state so they fall as soon as clr rises.
  always_comb begin
    sd_req       = 1'b0;
    sd_we        = 1'b0;
    sd_addr      = '0;
    wfifo_rd_req = 1'b0;
    rfifo_wr_req = 1'b0;
    unique case (state_q)
      StWrReq: begin
        sd_req  = 1'b1;
        sd_we   = 1'b1;
        sd_addr = ADDR_WIDTH'({wr_ptr_q, {BW{1'b0}}});
      end
      StRdReq: begin
        sd_req  = 1'b1;
        sd_addr = ADDR_WIDTH'({rd_ptr_q, {BW{1'b0}}});
      end
      StWrBurst: wfifo_rd_req = sd_wr_beat;
      StRdBurst: rfifo_wr_req = sd_rd_beat;
      default: ;
    endcase
    stored_bursts = stored_q;
    busy          = (state_q != StIdle);
  end

endmodule
